// File: rtl/ingress_forward_scheduler_if.sv
// Grant/handshake bundle between the buffering fabric, the forward scheduler and egress.
// master: scheduler side (drives grants and status); slave: fabric/egress side.
interface ingress_forward_scheduler_if #(
   parameter int NUM_PORTS = 15,
   parameter int PORT_BITS = 4
);
   logic [NUM_PORTS-1:0] port_ready;
   logic                 egress_ready;
   logic                 frame_done;
   logic [NUM_PORTS-1:0] forward_en;
   logic                 active;
   logic [PORT_BITS-1:0] active_port;
   logic                 timeout;

   modport master (
      input  port_ready, egress_ready, frame_done,
      output forward_en, active, active_port, timeout
   );

   modport slave (
      output port_ready, egress_ready, frame_done,
      input  forward_en, active, active_port, timeout
   );
endinterface

// File: rtl/ingress_forward_scheduler.sv
// Round-robin forward scheduler: one frame in flight at a time, one-cycle one-hot grant pulses.
// Optional WAIT watchdog enabled by defining FWD_WATCHDOG_EN.
module ingress_forward_scheduler #(
   parameter int NUM_PORTS      = 15,
   parameter int PORT_BITS      = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ingress_forward_scheduler_if.master bus,
   output logic                        dbg_state
);
   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [NUM_PORTS-1:0] forward_en_q, forward_en_d;
   logic [PORT_BITS-1:0] active_port_q, active_port_d;
   logic [PORT_BITS-1:0] last_port_q, last_port_d;
   logic                 timeout_q, timeout_d;
   logic                 found;
   logic [PORT_BITS-1:0] sel;
   logic                 expire;
   int                   idx;

   // Rotating priority: scan last_port+1 .. last_port+NUM_PORTS, first ready port wins.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int off = 1; off <= NUM_PORTS; off++) begin
         idx = (int'(last_port_q) + off) % NUM_PORTS;
         if (!found && bus.port_ready[idx]) begin
            found = 1'b1;
            sel   = PORT_BITS'(idx);
         end
      end
   end

`ifdef FWD_WATCHDOG_EN
   localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_BITS-1:0] wdog_q, wdog_d;

   // Held at zero in IDLE so the first WAIT cycle after a grant sees 0.
   always_comb begin
      wdog_d = '0;
      if (state_q == S_WAIT) wdog_d = wdog_q + CNT_BITS'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wdog_q <= '0;
      else        wdog_q <= wdog_d;
   end

   assign expire = (state_q == S_WAIT) && !bus.frame_done &&
                   (wdog_q == CNT_BITS'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      forward_en_d  = '0;
      active_port_d = active_port_q;
      last_port_d   = last_port_q;
      timeout_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.egress_ready && found) begin
               forward_en_d[sel] = 1'b1;
               active_port_d     = sel;
               state_d           = S_WAIT;
            end
         end
         S_WAIT: begin
            // frame_done has priority over a same-cycle watchdog expiry.
            if (bus.frame_done || expire) begin
               state_d     = S_IDLE;
               last_port_d = active_port_q;
               timeout_d   = expire;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         forward_en_q  <= '0;
         active_port_q <= '0;
         last_port_q   <= PORT_BITS'(NUM_PORTS - 1);
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         forward_en_q  <= forward_en_d;
         active_port_q <= active_port_d;
         last_port_q   <= last_port_d;
         timeout_q     <= timeout_d;
      end
   end

   assign bus.forward_en  = forward_en_q;
   assign bus.active      = (state_q == S_WAIT);
   assign bus.active_port = active_port_q;
   assign bus.timeout     = timeout_q;
   assign dbg_state       = logic'(state_q);
endmodule
